qam_adc_rx_frontend: RTL and testbench
======================================

// Module: qam_adc_rx_frontend
// PURPOSE
//  Receive-side counterpart of the QAM16 transmit DAC path. Accepts the complementary
//  14-bit offset-binary pair (a, ~a) from the ADC/loopback harness and checks pair
//  integrity. Converts each good sample back to two's complement in the 30-bit myqam
//  dout alignment (bits [20:7]) for the demodulator. A windowed signal-detect FSM
//  raises locked/fault status.
// PARAMETERS
//  THRESH    1024  |sample| >= THRESH counts as a hit (14-bit signed domain)
//  WIN_LEN   256   samples per detection window (>=2)
//  MIN_HITS  64    hits per window required to lock/stay locked (<=WIN_LEN)
//  ERR_MAX   8     consecutive pair errors that force FAULT (>=1)
// PORTS
//  sys_clk     in   1   system clock, all logic on rising edge
//  Rst         in   1   asynchronous, active-low reset
//  en          in   1   receiver enable; 0 forces IDLE
//  adc_a       in   14  offset-binary sample, true copy
//  adc_b       in   14  offset-binary sample, bitwise-inverted copy
//  dout        out  30  signed sample, [20:7]=data, [29:21] sign ext, [6:0]=0
//  dout_valid  out  1   dout holds a good sample this cycle
//  locked      out  1   FSM in LOCKED
//  fault       out  1   FSM in FAULT
//  err_cnt     out  16  total pair errors, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (Rst=0, async): all pipeline regs, dout, dout_valid, locked, fault, err_cnt,
//   window/hit/error counters = 0; FSM = IDLE.
//  Pipeline, 3 register stages:
//   S1 registers adc_a/adc_b at edge k. S2 registers ok=(b==~a) and s={~a[13],a[12:0]},
//   i.e. a-8192. S3 (edge k+2) drives dout and dout_valid.
//   dout=s sign-extended, shifted left by 7. dout_valid=ok&en. When !ok: dout=0, dout_valid=0.
//  Magnitude: |s| is computed as a 14-bit unsigned value; |-8192| = 8192 (no overflow).
//   Hit = ok && |s| >= THRESH.
//  Counters run only in SEARCH/LOCKED; they advance on each S2 sample.
//   win_cnt counts 0..WIN_LEN-1 and wraps. hit_cnt counts hits within the window;
//   error samples advance win_cnt but never hit_cnt.
//   Window end = the sample with win_cnt==WIN_LEN-1. The decision uses hit_cnt including
//   that sample; hit_cnt then clears.
//  FSM:
//   IDLE   : en=1 -> SEARCH (next edge).
//   SEARCH : at window end, hits>=MIN_HITS -> LOCKED.
//   LOCKED : at window end, hits<MIN_HITS -> SEARCH.
//   any of SEARCH/LOCKED : consecutive pair errors reach ERR_MAX -> FAULT.
//   FAULT  : held until en=0 -> IDLE.
//   en=0 in any state -> IDLE next edge; win/hit/consec counters clear.
//   locked=(state==LOCKED), fault=(state==FAULT); both are registered state decodes.
//  Error tracking: consec_err increments on !ok and clears on ok.
//   err_cnt increments on every !ok S2 sample regardless of state and en; it saturates
//   and clears only on Rst.
//  Simultaneous events: en=0 beats everything. FAULT beats a window-end decision in the
//   same cycle. A good sample on the ERR_MAX-th boundary resets consec_err, so no FAULT.
//  Reset mid-operation: everything returns to reset values immediately. The pipeline
//   refills and dout_valid rises no earlier than 3 edges after Rst deasserts.
// TESTING
//  1 a=14'h2000, b=~a, en=1 -> dout=0, dout_valid=1 at edge k+2; a=14'h3FFF -> dout=8191<<7;
//    a=0 -> dout=-8192<<7 (30'h3FF00000).
//  2 b=a (not inverted) for one sample -> that dout=0, dout_valid=0, err_cnt +1;
//    neighbouring samples unaffected.
//  3 defaults, |s|=2000 on all samples -> LOCKED after first full window (256 samples);
//    then |s|=100 -> back to SEARCH at next window end.
//  4 exactly 64 hits in a window -> lock; 63 hits -> stay in SEARCH.
//  5 8 consecutive pair errors -> fault=1, locked=0; en=0 -> IDLE; en=1 -> SEARCH.
//    7 errors then 1 good sample -> no fault.
//  6 Rst pulse while LOCKED -> all outputs 0 immediately; 65536+ errors -> err_cnt holds FFFF.

Source files
------------

// File: rtl/qam_adc_rx_frontend.sv
`default_nettype none
// ============================================================================
// qam_adc_rx_frontend : QAM16 ADC pair check, offset-binary to signed, signal detect
// Revision 1.0
// ============================================================================
module qam_adc_rx_frontend #(
    parameter int THRESH   = 1024,
    parameter int WIN_LEN  = 256,
    parameter int MIN_HITS = 64,
    parameter int ERR_MAX  = 8
) (
    input  logic        sys_clk,
    input  logic        Rst,
    input  logic        en,
    input  logic [13:0] adc_a,
    input  logic [13:0] adc_b,
    output logic [29:0] dout,
    output logic        dout_valid,
    output logic        locked,
    output logic        fault,
    output logic [15:0] err_cnt
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int HIT_W = $clog2(WIN_LEN + 1);
    localparam int ERR_W = $clog2(ERR_MAX + 1);

    localparam logic [13:0]      THRESH_U  = 14'(THRESH);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [HIT_W-1:0] MIN_HITSU = HIT_W'(MIN_HITS);
    localparam logic [ERR_W-1:0] ERR_MAXU  = ERR_W'(ERR_MAX);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    logic [13:0]      a1, b1;
    logic             v1, v2;
    logic             ok2;
    logic [13:0]      s2;
    logic [1:0]       state;
    logic [WIN_W-1:0] win_cnt;
    logic [HIT_W-1:0] hit_cnt;
    logic [ERR_W-1:0] consec_err;

    logic [13:0]      mag;
    logic             hit;
    logic             bad;
    logic             win_end;
    logic [HIT_W-1:0] hits_total;
    logic [ERR_W-1:0] consec_inc;

    // Negating -8192 wraps back to 14'h2000, which read unsigned is exactly 8192.
    assign mag        = s2[13] ? (~s2 + 14'd1) : s2;
    assign hit        = ok2 && (mag >= THRESH_U);
    assign bad        = v2 && !ok2;
    assign win_end    = (win_cnt == WIN_LAST);
    assign hits_total = hit_cnt + HIT_W'(hit);
    assign consec_inc = consec_err + ERR_W'(1);

    assign locked = (state == ST_LOCKED);
    assign fault  = (state == ST_FAULT);

    always_ff @(posedge sys_clk or negedge Rst) begin
        if (!Rst) begin
            a1         <= '0;
            b1         <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            ok2        <= 1'b0;
            s2         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err_cnt    <= '0;
            state      <= ST_IDLE;
            win_cnt    <= '0;
            hit_cnt    <= '0;
            consec_err <= '0;
        end else begin
            a1  <= adc_a;
            b1  <= adc_b;
            v1  <= 1'b1;
            v2  <= v1;
            ok2 <= v1 && (b1 == ~a1);
            s2  <= {~a1[13], a1[12:0]};

            dout       <= ok2 ? {{9{s2[13]}}, s2, 7'b0} : 30'd0;
            dout_valid <= ok2 & en;

            if (bad && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end

            if (!en) begin
                state      <= ST_IDLE;
                win_cnt    <= '0;
                hit_cnt    <= '0;
                consec_err <= '0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_SEARCH;
                    ST_SEARCH, ST_LOCKED: begin
                        if (v2) begin
                            // A fault outranks any window decision on the same sample.
                            if (!ok2 && (consec_inc >= ERR_MAXU)) begin
                                state      <= ST_FAULT;
                                win_cnt    <= '0;
                                hit_cnt    <= '0;
                                consec_err <= '0;
                            end else begin
                                consec_err <= ok2 ? '0 : consec_inc;
                                if (win_end) begin
                                    win_cnt <= '0;
                                    hit_cnt <= '0;
                                    if ((state == ST_SEARCH) && (hits_total >= MIN_HITSU)) begin
                                        state <= ST_LOCKED;
                                    end else if ((state == ST_LOCKED) && (hits_total < MIN_HITSU)) begin
                                        state <= ST_SEARCH;
                                    end
                                end else begin
                                    win_cnt <= win_cnt + WIN_W'(1);
                                    hit_cnt <= hits_total;
                                end
                            end
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qam_adc_rx_frontend.sv
`default_nettype none
// ============================================================================
// tb_qam_adc_rx_frontend : vector table, directed corner sequences, random vs model
// Revision 1.0
// ============================================================================
module tb_qam_adc_rx_frontend;

    localparam int THRESH   = 1024;
    localparam int WIN_LEN  = 256;
    localparam int MIN_HITS = 64;
    localparam int ERR_MAX  = 8;

    logic        sys_clk = 1'b0;
    logic        Rst;
    logic        en;
    logic [13:0] adc_a, adc_b;
    logic [29:0] dout;
    logic        dout_valid, locked, fault;
    logic [15:0] err_cnt;

    qam_adc_rx_frontend #(
        .THRESH(THRESH), .WIN_LEN(WIN_LEN), .MIN_HITS(MIN_HITS), .ERR_MAX(ERR_MAX)
    ) dut (
        .sys_clk(sys_clk), .Rst(Rst), .en(en), .adc_a(adc_a), .adc_b(adc_b),
        .dout(dout), .dout_valid(dout_valid), .locked(locked), .fault(fault),
        .err_cnt(err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: samples seen as integers, detector as a named mode.
    typedef struct { logic [13:0] a; logic [13:0] b; } pair_t;
    typedef enum { M_OFF, M_HUNT, M_LOCK, M_BROKEN } mode_t;
    pair_t       pipe[$];
    mode_t       m_mode;
    int          m_seen, m_hits, m_run, m_err;
    logic [29:0] m_dout;
    logic        m_valid;

    function automatic void model_reset();
        pipe.delete();
        m_mode = M_OFF; m_seen = 0; m_hits = 0; m_run = 0; m_err = 0;
        m_dout = '0; m_valid = 1'b0;
    endfunction

    function automatic void model_edge(input logic [13:0] a, input logic [13:0] b, input logic e);
        pair_t p;
        pair_t x;
        bit    have, ok, is_hit;
        int    sv, mag;
        p.a = a; p.b = b;
        pipe.push_back(p);
        if (pipe.size() > 3) void'(pipe.pop_front());
        have = (pipe.size() == 3);
        x = pipe[0];
        ok = have && (x.b == ~x.a);
        sv = int'(x.a) - 8192;
        mag = (sv < 0) ? -sv : sv;
        is_hit = ok && (mag >= THRESH);
        m_dout  = ok ? 30'(sv * 128) : 30'd0;
        m_valid = ok && e;
        if (have && !ok && m_err < 65535) m_err++;
        if (!e) begin
            m_mode = M_OFF; m_seen = 0; m_hits = 0; m_run = 0;
        end else if (m_mode == M_OFF) begin
            m_mode = M_HUNT;
        end else if ((m_mode == M_HUNT || m_mode == M_LOCK) && have) begin
            if (!ok && (m_run + 1 >= ERR_MAX)) begin
                m_mode = M_BROKEN; m_seen = 0; m_hits = 0; m_run = 0;
            end else begin
                m_run = ok ? 0 : m_run + 1;
                m_hits += is_hit ? 1 : 0;
                m_seen++;
                if (m_seen == WIN_LEN) begin
                    if (m_hits >= MIN_HITS) m_mode = M_LOCK;
                    else m_mode = M_HUNT;
                    m_seen = 0; m_hits = 0;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [13:0] a, input logic [13:0] b, input logic e);
        adc_a = a; adc_b = b; en = e;
        @(posedge sys_clk);
        model_edge(a, b, e);
        @(negedge sys_clk);
        check("dout", 64'(dout), 64'(m_dout));
        check("dout_valid", 64'(dout_valid), 64'(m_valid));
        check("locked", 64'(locked), 64'(m_mode == M_LOCK));
        check("fault", 64'(fault), 64'(m_mode == M_BROKEN));
        check("err_cnt", 64'(err_cnt), 64'(m_err));
    endtask

    task automatic good(input int sv, input logic e);
        logic [13:0] a;
        a = 14'(sv + 8192);
        tick(a, ~a, e);
    endtask

    task automatic broken(input int sv, input logic e);
        logic [13:0] a;
        a = 14'(sv + 8192);
        tick(a, a, e);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_dout"}, 64'(dout), 64'd0);
        check({name, "_valid"}, 64'(dout_valid), 64'd0);
        check({name, "_locked"}, 64'(locked), 64'd0);
        check({name, "_fault"}, 64'(fault), 64'd0);
        check({name, "_err"}, 64'(err_cnt), 64'd0);
    endtask

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic [29:0] exp_dout;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 14'h2000, b: 14'h1FFF, exp_dout: 30'h0000_0000, exp_valid: 1'b1};
        vecs[1] = '{a: 14'h3FFF, b: 14'h0000, exp_dout: 30'h000F_FF80, exp_valid: 1'b1};
        vecs[2] = '{a: 14'h0000, b: 14'h3FFF, exp_dout: 30'h3FF0_0000, exp_valid: 1'b1};
        vecs[3] = '{a: 14'h1000, b: 14'h1000, exp_dout: 30'h0000_0000, exp_valid: 1'b0};
        vecs[4] = '{a: 14'h2100, b: 14'h1EFF, exp_dout: 30'h0000_8000, exp_valid: 1'b1};
        vecs[5] = '{a: 14'h1F00, b: 14'h20FF, exp_dout: 30'h3FFF_8000, exp_valid: 1'b1};

        Rst = 1'b0; en = 1'b0; adc_a = '0; adc_b = '0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        check_outputs_zero("reset");
        Rst = 1'b1;

        // Conversion table, observed two edges after each sample is presented
        for (int i = 0; i < 8; i++) begin
            if (i < 6) tick(vecs[i].a, vecs[i].b, 1'b1);
            else good(0, 1'b1);
            if (i >= 2) begin
                check("table_dout", 64'(dout), 64'(vecs[i-2].exp_dout));
                check("table_valid", 64'(dout_valid), 64'(vecs[i-2].exp_valid));
            end
        end
        check("table_errcnt", 64'(err_cnt), 64'd1);

        // Strong signal locks, weak signal drops back
        repeat (3) good(0, 1'b0);
        for (int i = 0; i < 300; i++) good((i % 2) ? 2000 : -2000, 1'b1);
        check("lock_strong", 64'(locked), 64'd1);
        for (int i = 0; i < 300; i++) good((i % 2) ? 100 : -100, 1'b1);
        check("unlock_weak", 64'(locked), 64'd0);

        // Exactly MIN_HITS hits at the threshold edge locks
        repeat (3) good(0, 1'b0);
        for (int i = 0; i < 260; i++) good((i < 64) ? 1024 : 1023, 1'b1);
        check("lock_64hits", 64'(locked), 64'd1);

        // One short of MIN_HITS never locks
        repeat (3) good(0, 1'b0);
        for (int i = 0; i < 600; i++) good((i < 63) ? -1024 : -1023, 1'b1);
        check("nolock_63hits", 64'(locked), 64'd0);

        // ERR_MAX consecutive pair errors fault; en low/high recovers to search
        repeat (2) good(0, 1'b0);
        repeat (10) good(3000, 1'b1);
        repeat (8) broken(3000, 1'b1);
        repeat (2) good(3000, 1'b1);
        check("fault_set", 64'(fault), 64'd1);
        check("fault_unlocked", 64'(locked), 64'd0);
        good(0, 1'b0);
        check("fault_cleared", 64'(fault), 64'd0);
        repeat (4) good(0, 1'b1);
        repeat (2) begin
            repeat (7) broken(-3000, 1'b1);
            good(-3000, 1'b1);
        end
        repeat (2) good(-3000, 1'b1);
        check("no_fault_7err", 64'(fault), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int          sv;
            logic        e;
            logic [13:0] a;
            case ($urandom_range(0, 3))
                0: sv = int'($urandom_range(0, 16383)) - 8192;
                1: sv = int'($urandom_range(1020, 1030)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
                2: sv = -8192;
                default: sv = int'($urandom_range(1500, 8191)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
            endcase
            e = ($urandom_range(0, 199) != 0);
            a = 14'(sv + 8192);
            if ($urandom_range(0, 15) == 0) tick(a, 14'($urandom_range(0, 16383)), e);
            else tick(a, ~a, e);
        end

        // Asynchronous reset while locked
        good(0, 1'b0);
        for (int i = 0; i < 300; i++) good((i % 3 == 0) ? -3000 : 3000, 1'b1);
        check("pre_rst_locked", 64'(locked), 64'd1);
        #2 Rst = 1'b0;
        #1 check_outputs_zero("async_rst");
        model_reset();
        repeat (2) @(negedge sys_clk);
        Rst = 1'b1;
        repeat (6) good(4000, 1'b1);

        // err_cnt saturation
        for (int i = 0; i < 65540; i++) broken(i % 8000, 1'b0);
        check("err_sat", 64'(err_cnt), 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
